// File: rtl/noc_inj_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_inj_pkg
// Description : Shared flit-width, slot-state and helper definitions for the
//               NoC injection/ejection arbitration blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

package noc_inj_pkg;

  localparam int FLIT_W = `PAYLOAD_SIZE + `ADDR_BITS;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Minimum of 1 so a pointer always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << r) < value) r = k + 1;
    end
    return r;
  endfunction

endpackage : noc_inj_pkg
`default_nettype wire

// File: rtl/par_injection_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : par_injection_arbiter_if
// Description : Source-side and router-side signals of the injection arbiter.
//               grant_count exists only when INJ_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface par_injection_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int FLIT_W = noc_inj_pkg::FLIT_W
) ();

  logic [N_REQ*FLIT_W-1:0] in_data;
  logic [N_REQ-1:0]        in_valid;
  logic [N_REQ-1:0]        in_busy;
  logic [FLIT_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_busy;
  logic [N_REQ-1:0]        overflow_err;
`ifdef INJ_ARB_STATS_EN
  logic [N_REQ*16-1:0]     grant_count;

  modport slave (
    input  in_data, in_valid, out_busy,
    output in_busy, out_data, out_valid, overflow_err, grant_count
  );
  modport master (
    output in_data, in_valid, out_busy,
    input  in_busy, out_data, out_valid, overflow_err, grant_count
  );
`else
  modport slave (
    input  in_data, in_valid, out_busy,
    output in_busy, out_data, out_valid, overflow_err
  );
  modport master (
    output in_data, in_valid, out_busy,
    input  in_busy, out_data, out_valid, overflow_err
  );
`endif

endinterface : par_injection_arbiter_if
`default_nettype wire

// File: rtl/par_injection_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first set request at or
//               after ptr, wrapping modulo N_REQ (non-power-of-2 safe).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = noc_inj_pkg::clog2(N_REQ)
) (
  input  wire logic [N_REQ-1:0] req,
  input  wire logic [PTR_W-1:0] ptr,
  output logic                  any_grant,
  output logic [PTR_W-1:0]      winner
);

  int               w_idx;
  logic [PTR_W-1:0] w_sel;

  // Scan from farthest to nearest offset so the nearest request wins last.
  always_comb begin
    any_grant = 1'b0;
    winner    = '0;
    w_idx     = 0;
    w_sel     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      w_sel = PTR_W'(w_idx);
      if (req[w_sel]) begin
        any_grant = 1'b1;
        winner    = w_sel;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/par_injection_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : par_injection_arbiter
// Description : Shares one router injection port among N_REQ sources using
//               one-entry slots and round-robin grant. Optional per-source
//               grant counters are built when INJ_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module par_injection_arbiter
  import noc_inj_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int FLIT_W = noc_inj_pkg::FLIT_W,
  parameter int PTR_W  = noc_inj_pkg::clog2(N_REQ)
) (
  input  wire logic               clk,
  input  wire logic               reset,
  par_injection_arbiter_if.slave  bus
);

  slot_state_t       r_state [N_REQ];
  logic [FLIT_W-1:0] r_slot  [N_REQ];
  logic [PTR_W-1:0]  r_ptr;
  logic [FLIT_W-1:0] r_out_data;
  logic              r_out_valid;
  logic [N_REQ-1:0]  r_overflow;

  logic [N_REQ-1:0]  w_req;
  logic [N_REQ-1:0]  w_grant_vec;
  logic              w_any;
  logic              w_grant;
  logic [PTR_W-1:0]  w_winner;

  always_comb begin
    w_req       = '0;
    w_grant_vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_req[i]       = (r_state[i] == SLOT_FULL);
      w_grant_vec[i] = w_grant && (w_winner == PTR_W'(i));
    end
  end

  assign w_grant = w_any && !bus.out_busy;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req       (w_req),
    .ptr       (r_ptr),
    .any_grant (w_any),
    .winner    (w_winner)
  );

`ifdef INJ_ARB_STATS_EN
  logic [15:0] r_grant_cnt [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign bus.grant_count[g*16 +: 16] = r_grant_cnt[g];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        r_state[i] <= SLOT_EMPTY;
        r_slot[i]  <= '0;
`ifdef INJ_ARB_STATS_EN
        r_grant_cnt[i] <= '0;
`endif
      end
      r_ptr       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= '0;
    end else begin
      r_out_valid <= w_grant;
      if (w_grant) begin
        r_out_data <= r_slot[w_winner];
        r_ptr      <= (w_winner == PTR_W'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
      end
      for (int i = 0; i < N_REQ; i++) begin
        // A flit arriving while full is dropped even if the slot drains this cycle.
        if (r_state[i] == SLOT_FULL) begin
          if (bus.in_valid[i]) r_overflow[i] <= 1'b1;
          if (w_grant_vec[i])  r_state[i]    <= SLOT_EMPTY;
        end else if (bus.in_valid[i]) begin
          r_slot[i]  <= bus.in_data[i*FLIT_W +: FLIT_W];
          r_state[i] <= SLOT_FULL;
        end
`ifdef INJ_ARB_STATS_EN
        if (w_grant_vec[i] && (r_grant_cnt[i] != 16'hFFFF))
          r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
`endif
      end
    end
  end

  assign bus.in_busy      = w_req;
  assign bus.out_data     = r_out_data;
  assign bus.out_valid    = r_out_valid;
  assign bus.overflow_err = r_overflow;

endmodule : par_injection_arbiter
`default_nettype wire

// File: tb/tb_par_injection_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_par_injection_arbiter
// Description : Directed self-checking bench for par_injection_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_par_injection_arbiter;

  localparam int N_REQ = 4;
  localparam int FW    = noc_inj_pkg::FLIT_W;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  par_injection_arbiter_if #(.N_REQ(N_REQ), .FLIT_W(FW)) bus_if ();

  par_injection_arbiter #(.N_REQ(N_REQ), .FLIT_W(FW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  task automatic set_src(input int i, input logic [FW-1:0] d);
    bus_if.in_data[i*FW +: FW] = d;
  endtask

  task automatic chk_out(input string tag, input logic [FW-1:0] d, input logic [3:0] busy);
    check({tag, "_valid"}, 64'(bus_if.out_valid), 64'd1);
    check({tag, "_data"},  64'(bus_if.out_data),  64'(d));
    check({tag, "_busy"},  64'(bus_if.in_busy),   64'(busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    bus_if.in_valid  = '0;
    bus_if.in_data   = '0;
    bus_if.out_busy  = 1'b0;
    nclk(); nclk();
    check("rst_valid", 64'(bus_if.out_valid),    64'd0);
    check("rst_data",  64'(bus_if.out_data),     64'd0);
    check("rst_busy",  64'(bus_if.in_busy),      64'd0);
    check("rst_ovf",   64'(bus_if.overflow_err), 64'd0);
`ifdef INJ_ARB_STATS_EN
    check("rst_cnt",   64'(bus_if.grant_count),  64'd0);
`endif
    reset = 1'b0;

    // Fairness: all four load together, rr_ptr=0 -> 0,1,2,3
    for (int i = 0; i < N_REQ; i++) set_src(i, FW'(12'h100 + i));
    bus_if.in_valid = 4'hF;
    nclk(); bus_if.in_valid = '0;
    check("fair_busy",  64'(bus_if.in_busy),   64'hF);
    check("fair_idle",  64'(bus_if.out_valid), 64'd0);
    nclk(); chk_out("fair_g0", 12'h100, 4'b1110);
    nclk(); chk_out("fair_g1", 12'h101, 4'b1100);
    nclk(); chk_out("fair_g2", 12'h102, 4'b1000);
    nclk(); chk_out("fair_g3", 12'h103, 4'b0000);
    nclk();
    check("fair_end_valid", 64'(bus_if.out_valid), 64'd0);
    check("fair_hold_data", 64'(bus_if.out_data),  64'h103);
`ifdef INJ_ARB_STATS_EN
    check("fair_cnt", 64'(bus_if.grant_count), {4{16'd1}});
`endif

    // rr_ptr wrapped to 0: sources 0 and 3 -> 0 first
    set_src(0, 12'h200); set_src(3, 12'h203);
    bus_if.in_valid = 4'b1001;
    nclk(); bus_if.in_valid = '0;
    nclk(); chk_out("wrap_g0", 12'h200, 4'b1000);
    nclk(); chk_out("wrap_g3", 12'h203, 4'b0000);
    nclk();

    // Basic pass, source 2: busy next cycle, out two cycles after in
    set_src(2, 12'h025);
    bus_if.in_valid = 4'b0100;
    nclk(); bus_if.in_valid = '0;
    check("basic_busy",  64'(bus_if.in_busy),   64'b0100);
    check("basic_idle",  64'(bus_if.out_valid), 64'd0);
    nclk();
    check("basic_valid", 64'(bus_if.out_valid), 64'd1);
    check("basic_data",  64'(bus_if.out_data),  64'h025);
    nclk();
    check("basic_drop_valid", 64'(bus_if.out_valid), 64'd0);
    check("basic_free",       64'(bus_if.in_busy),   64'd0);

    // Source 1 alone moves rr_ptr from 3 to 2
    set_src(1, 12'h0A1);
    bus_if.in_valid = 4'b0010;
    nclk(); bus_if.in_valid = '0;
    nclk(); chk_out("pre_rot", 12'h0A1, 4'b0000);
    nclk();

    // Rotation: 1 and 3 refilled as soon as free, rr_ptr=2 -> 3,1,3,1
    set_src(1, 12'h301); set_src(3, 12'h303);
    bus_if.in_valid = 4'b1010;
    nclk(); bus_if.in_valid = '0;
    check("rot_busy", 64'(bus_if.in_busy), 64'b1010);
    nclk(); chk_out("rot_g3a", 12'h303, 4'b0010);
    set_src(3, 12'h313); bus_if.in_valid = 4'b1000;
    nclk(); chk_out("rot_g1a", 12'h301, 4'b1000);
    set_src(1, 12'h311); bus_if.in_valid = 4'b0010;
    nclk(); chk_out("rot_g3b", 12'h313, 4'b0010);
    bus_if.in_valid = '0;
    nclk(); chk_out("rot_g1b", 12'h311, 4'b0000);
    nclk();
    check("rot_end", 64'(bus_if.out_valid), 64'd0);

    // Back-pressure: slots 0,1 held for 10 cycles, rr_ptr=2 -> 0 then 1
    bus_if.out_busy = 1'b1;
    set_src(0, 12'h400); set_src(1, 12'h401);
    bus_if.in_valid = 4'b0011;
    nclk(); bus_if.in_valid = '0;
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", 64'(bus_if.out_valid), 64'd0);
      check("bp_busy",  64'(bus_if.in_busy),   64'b0011);
      if (c < 9) nclk();
    end
    bus_if.out_busy = 1'b0;
    nclk(); chk_out("bp_g0", 12'h400, 4'b0010);
    nclk(); chk_out("bp_g1", 12'h401, 4'b0000);
    nclk();

    // Overflow: two back-to-back flits from source 0 while stalled
    bus_if.out_busy = 1'b1;
    set_src(0, 12'h500); bus_if.in_valid = 4'b0001;
    nclk();
    check("ovf_none_yet", 64'(bus_if.overflow_err), 64'd0);
    set_src(0, 12'h5FF);
    nclk(); bus_if.in_valid = '0;
    check("ovf_set",  64'(bus_if.overflow_err), 64'b0001);
    check("ovf_busy", 64'(bus_if.in_busy),      64'b0001);
    nclk(); nclk();
    check("ovf_sticky", 64'(bus_if.overflow_err), 64'b0001);
    bus_if.out_busy = 1'b0;
    nclk(); chk_out("ovf_first", 12'h500, 4'b0000);
    nclk();
    check("ovf_no_second",  64'(bus_if.out_valid),    64'd0);
    check("ovf_sticky_end", 64'(bus_if.overflow_err), 64'b0001);

    // Async reset mid-grant, then first grant restarts at rr_ptr=0
    set_src(2, 12'h602); set_src(3, 12'h603);
    bus_if.in_valid = 4'b1100;
    nclk(); bus_if.in_valid = '0;
    nclk(); chk_out("mid_g2", 12'h602, 4'b1000);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 64'(bus_if.out_valid),    64'd0);
    check("arst_data",  64'(bus_if.out_data),     64'd0);
    check("arst_busy",  64'(bus_if.in_busy),      64'd0);
    check("arst_ovf",   64'(bus_if.overflow_err), 64'd0);
`ifdef INJ_ARB_STATS_EN
    check("arst_cnt",   64'(bus_if.grant_count),  64'd0);
`endif
    nclk(); reset = 1'b0;
    set_src(0, 12'h700); set_src(3, 12'h703);
    bus_if.in_valid = 4'b1001;
    nclk(); bus_if.in_valid = '0;
    nclk(); chk_out("post_g0", 12'h700, 4'b1000);
    nclk(); chk_out("post_g3", 12'h703, 4'b0000);
    nclk();
    check("post_end", 64'(bus_if.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_par_injection_arbiter
`default_nettype wire
